wb_tia_audio: RTL and testbench

//  Multi-channel Atari 2600 TIA-compatible sound generator on a Wishbone slave port. Replaces the fixed
//  two-counter square-wave audio: each channel runs the real AUDC/AUDF/AUDV model (4/5/9-bit polys, dividers,
//  4-bit volume). Channels are mixed into one PCM sample and a first-order sigma-delta 1-bit output for a pin.

---
 rtl/tia_audio_pkg.sv | 45 ++++
 rtl/tia_audio_channel.sv | 130 +++++++++++++
 rtl/wb_tia_audio.sv | 151 +++++++++++++++
 tb/tb_wb_tia_audio.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tia_audio_pkg.sv
// Shared definitions for the TIA-compatible sound generator: AUDC modes, poly seeds/steps,
// register offsets.
package tia_audio_pkg;

  typedef enum logic [3:0] {
    AudcSet0    = 4'h0,
    AudcPoly4   = 4'h1,
    AudcDiv15P4 = 4'h2,
    AudcP5P4    = 4'h3,
    AudcDiv2A   = 4'h4,
    AudcDiv2B   = 4'h5,
    AudcDiv31A  = 4'h6,
    AudcP5Div2  = 4'h7,
    AudcPoly9   = 4'h8,
    AudcPoly5   = 4'h9,
    AudcDiv31B  = 4'hA,
    AudcSet1    = 4'hB,
    AudcDiv6A   = 4'hC,
    AudcDiv6B   = 4'hD,
    AudcDiv93   = 4'hE,
    AudcP5Div6  = 4'hF
  } audc_mode_e;

  localparam logic [1:0] RegAudc = 2'd0;
  localparam logic [1:0] RegAudf = 2'd1;
  localparam logic [1:0] RegAudv = 2'd2;

  localparam logic [3:0] Poly4Seed = 4'hF;
  localparam logic [4:0] Poly5Seed = 5'h1F;
  localparam logic [8:0] Poly9Seed = 9'h1FF;

  // Fibonacci LFSRs shifting left; the msb is the output tap.
  function automatic logic [3:0] poly4_next(input logic [3:0] p);
    return {p[2:0], p[3] ^ p[2]};
  endfunction

  function automatic logic [4:0] poly5_next(input logic [4:0] p);
    return {p[3:0], p[4] ^ p[2]};
  endfunction

  function automatic logic [8:0] poly9_next(input logic [8:0] p);
    return {p[7:0], p[8] ^ p[4]};
  endfunction

endpackage

// File: rtl/tia_audio_channel.sv
// One TIA sound channel: frequency divider, poly counters and AUDC-selected waveform,
// scaled by AUDV into a 4-bit level.
module tia_audio_channel
  import tia_audio_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic [3:0] audc_i,
  input  logic [4:0] audf_i,
  input  logic [3:0] audv_i,
  output logic [3:0] level_o
);

  logic [4:0] fcnt_q, fcnt_d;
  logic [3:0] poly4_q, poly4_d;
  logic [4:0] poly5_q, poly5_d;
  logic [8:0] poly9_q, poly9_d;
  logic [1:0] div3_q, div3_d;
  logic [3:0] div15_q, div15_d;
  logic [4:0] div31_q, div31_d;
  logic       out_q, out_d;

  logic       step;
  logic [3:0] poly4_n;
  logic       wrap3, wrap15, wrap31;
  logic [1:0] div3_inc;
  logic [3:0] div15_inc;
  logic [4:0] div31_inc;
  audc_mode_e mode;

  assign mode      = audc_mode_e'(audc_i);
  assign step      = tick_i && (fcnt_q == audf_i);
  assign poly4_n   = poly4_next(poly4_q);
  assign wrap3     = (div3_q == 2'd2);
  assign wrap15    = (div15_q == 4'd14);
  assign wrap31    = (div31_q == 5'd30);
  assign div3_inc  = wrap3 ? 2'd0 : div3_q + 2'd1;
  assign div15_inc = wrap15 ? 4'd0 : div15_q + 4'd1;
  assign div31_inc = wrap31 ? 5'd0 : div31_q + 5'd1;

  always_comb begin
    fcnt_d  = fcnt_q;
    poly4_d = poly4_q;
    poly5_d = poly5_q;
    poly9_d = poly9_q;
    div3_d  = div3_q;
    div15_d = div15_q;
    div31_d = div31_q;
    out_d   = out_q;
    // A counter left above a freshly lowered AUDF runs on through 31 back to 0.
    if (tick_i) fcnt_d = step ? 5'd0 : fcnt_q + 5'd1;
    if (step) begin
      poly4_d = poly4_n;
      poly5_d = poly5_next(poly5_q);
      poly9_d = poly9_next(poly9_q);
      unique case (mode)
        AudcSet0, AudcSet1: out_d = 1'b1;
        AudcPoly4:          out_d = poly4_n[3];
        AudcDiv15P4: begin
          div15_d = div15_inc;
          if (wrap15) begin
            out_d = poly4_n[3];
          end else begin
            poly4_d = poly4_q;
            out_d   = poly4_q[3];
          end
        end
        AudcP5P4: begin
          if (poly5_q[4]) begin
            out_d = poly4_n[3];
          end else begin
            poly4_d = poly4_q;
            out_d   = poly4_q[3];
          end
        end
        AudcDiv2A, AudcDiv2B: out_d = ~out_q;
        AudcDiv31A, AudcDiv31B: begin
          div31_d = div31_inc;
          if (wrap31) out_d = ~out_q;
        end
        AudcP5Div2: if (poly5_q[4]) out_d = ~out_q;
        AudcPoly9:  out_d = poly9_d[8];
        AudcPoly5:  out_d = poly5_d[4];
        AudcDiv6A, AudcDiv6B: begin
          div3_d = div3_inc;
          if (wrap3) out_d = ~out_q;
        end
        AudcDiv93: begin
          div3_d = div3_inc;
          if (wrap3) begin
            div31_d = div31_inc;
            if (wrap31) out_d = ~out_q;
          end
        end
        AudcP5Div6: begin
          if (poly5_q[4]) begin
            div3_d = div3_inc;
            if (wrap3) out_d = ~out_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt_q  <= '0;
      poly4_q <= Poly4Seed;
      poly5_q <= Poly5Seed;
      poly9_q <= Poly9Seed;
      div3_q  <= '0;
      div15_q <= '0;
      div31_q <= '0;
      out_q   <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      poly4_q <= poly4_d;
      poly5_q <= poly5_d;
      poly9_q <= poly9_d;
      div3_q  <= div3_d;
      div15_q <= div15_d;
      div31_q <= div31_d;
      out_q   <= out_d;
    end
  end

  assign level_o = out_q ? audv_i : 4'd0;

endmodule

// File: rtl/wb_tia_audio.sv
// Wishbone-mapped multi-channel TIA sound generator: register file, audio-tick prescaler,
// channel mixer and first-order sigma-delta PDM output.
module wb_tia_audio
  import tia_audio_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CLK_DIV   = 512,
  parameter int unsigned WB_ADDR_W = 5,
  localparam int unsigned MIX_W    = 4 + $clog2(NUM_CH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [WB_ADDR_W-1:0] adr_i,
  input  logic [7:0]           dat_i,
  output logic                 ack_o,
  output logic [7:0]           dat_o,
  output logic [MIX_W-1:0]     sample_o,
  output logic                 sample_vld_o,
  output logic                 audio_o
);

  localparam int unsigned ChW  = WB_ADDR_W - 2;
  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [3:0] audc_q [NUM_CH];
  logic [3:0] audc_d [NUM_CH];
  logic [4:0] audf_q [NUM_CH];
  logic [4:0] audf_d [NUM_CH];
  logic [3:0] audv_q [NUM_CH];
  logic [3:0] audv_d [NUM_CH];
  logic [3:0] level  [NUM_CH];

  logic             ack_q, ack_d;
  logic [7:0]       dat_q, dat_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [MIX_W-1:0] sample_q, sample_d;
  logic             vld_q;
  logic [MIX_W:0]   acc_q, acc_d;

  logic [ChW-1:0]   adr_ch;
  logic [1:0]       adr_off;
  logic             adr_ok;
  logic             access;
  logic [7:0]       rd_data;
  logic [MIX_W-1:0] mix_sum;
  logic             tick;
  logic             unused_dat;

  assign adr_ch     = adr_i[WB_ADDR_W-1:2];
  assign adr_off    = adr_i[1:0];
  assign adr_ok     = (32'(adr_ch) < NUM_CH);
  // The transfer completes on the edge that raises ack.
  assign access     = stb_i && !ack_q;
  assign unused_dat = ^dat_i[7:5];

  always_comb begin
    rd_data = 8'h00;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      audc_d[c] = audc_q[c];
      audf_d[c] = audf_q[c];
      audv_d[c] = audv_q[c];
      if (adr_ok && (32'(adr_ch) == c)) begin
        unique case (adr_off)
          RegAudc: begin
            rd_data = {4'h0, audc_q[c]};
            if (access && we_i) audc_d[c] = dat_i[3:0];
          end
          RegAudf: begin
            rd_data = {3'h0, audf_q[c]};
            if (access && we_i) audf_d[c] = dat_i[4:0];
          end
          RegAudv: begin
            rd_data = {4'h0, audv_q[c]};
            if (access && we_i) audv_d[c] = dat_i[3:0];
          end
          default: rd_data = 8'h00;
        endcase
      end
    end
  end

  always_comb begin
    ack_d = access;
    dat_d = (access && !we_i) ? rd_data : 8'h00;
  end

  assign tick = (pre_q == PreW'(CLK_DIV - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    tia_audio_channel u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .tick_i  (tick),
      .audc_i  (audc_q[g]),
      .audf_i  (audf_q[g]),
      .audv_i  (audv_q[g]),
      .level_o (level[g])
    );
  end

  // Levels still reflect pre-tick state, so an AUDV write on a tick edge lands next tick.
  always_comb begin
    mix_sum = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      mix_sum = mix_sum + MIX_W'(level[c]);
    end
    sample_d = tick ? mix_sum : sample_q;
    acc_d    = {1'b0, acc_q[MIX_W-1:0]} + {1'b0, sample_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        audc_q[c] <= '0;
        audf_q[c] <= '0;
        audv_q[c] <= '0;
      end
      ack_q    <= 1'b0;
      dat_q    <= '0;
      pre_q    <= '0;
      sample_q <= '0;
      vld_q    <= 1'b0;
      acc_q    <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        audc_q[c] <= audc_d[c];
        audf_q[c] <= audf_d[c];
        audv_q[c] <= audv_d[c];
      end
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      pre_q    <= pre_d;
      sample_q <= sample_d;
      vld_q    <= tick;
      acc_q    <= acc_d;
    end
  end

  assign ack_o        = ack_q;
  assign dat_o        = dat_q;
  assign sample_o     = sample_q;
  assign sample_vld_o = vld_q;
  assign audio_o      = acc_q[MIX_W];

endmodule

// File: tb/tb_wb_tia_audio.sv
// Directed bench for wb_tia_audio: register access, tone timing, poly9 waveform, mixing,
// sigma-delta duty and asynchronous reset, with queued expectations.
module tb_wb_tia_audio;

  localparam int unsigned NumCh  = 2;
  localparam int unsigned ClkDiv = 16;
  localparam int unsigned AdrW   = 5;
  localparam int unsigned MixW   = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stb = 1'b0;
  logic            we = 1'b0;
  logic [AdrW-1:0] adr = '0;
  logic [7:0]      wdat = '0;
  logic            ack;
  logic [7:0]      rdat;
  logic [MixW-1:0] sample;
  logic            vld;
  logic            audio;

  int          errors = 0;
  int          checks = 0;
  int          exp_q[$];
  logic [7:0]  rd_sb[$];
  int          vld_cnt;
  bit          p9_seq[1024];

  always #5 clk = ~clk;

  wb_tia_audio #(
    .NUM_CH    (NumCh),
    .CLK_DIV   (ClkDiv),
    .WB_ADDR_W (AdrW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .stb_i        (stb),
    .we_i         (we),
    .adr_i        (adr),
    .dat_i        (wdat),
    .ack_o        (ack),
    .dat_o        (rdat),
    .sample_o     (sample),
    .sample_vld_o (vld),
    .audio_o      (audio)
  );

  // Counts sample pulses since reset release; pulse n samples the channel after n-1 steps.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_cnt <= 0;
    else if (vld) vld_cnt <= vld_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [AdrW-1:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    int n;
    @(negedge clk);
    stb = 1'b1; we = w; adr = a; wdat = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 4);
    chk("ack_latency", 32'(n), 32'd1);
    q = rdat;
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ack_single", 32'(ack), 32'd0);
  endtask

  task automatic wb_write(input logic [AdrW-1:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_read(input string tag, input logic [AdrW-1:0] a, input logic [7:0] e);
    logic [7:0] q;
    logic [7:0] x;
    rd_sb.push_back(e);
    wb_xfer(1'b0, a, 8'h00, q);
    x = rd_sb.pop_front();
    chk(tag, 32'(q), 32'(x));
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (vld !== 1'b1 && n < 4 * ClkDiv);
    chk("vld_seen", 32'(vld), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit [8:0] s;
    int       prev, n, cnt, idx, e;
    logic [MixW-1:0] cur;

    s = 9'h1FF;
    p9_seq[0] = 1'b1;
    for (int k = 1; k < 1024; k++) begin
      s = {s[7:0], s[8] ^ s[4]};
      p9_seq[k] = s[8];
    end

    // Reset state
    #23;
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_audio", 32'(audio), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", 32'(rdat), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) wb_read("rst_reg", AdrW'(a), 8'h00);

    // Toggle every tick
    wb_write(5'd0, 8'h04);
    wb_write(5'd1, 8'h00);
    wb_write(5'd2, 8'h0F);
    wait_vld();
    wait_vld();
    wait_vld();
    prev = int'(sample);
    chk("t1_level_0_or_15", 32'((prev == 0) || (prev == 15)), 32'd1);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(15 - prev);
      prev = 15 - prev;
      wait_vld();
      e = exp_q.pop_front();
      chk("t1_toggle", 32'(sample), 32'(e));
    end

    // AUDF=9: toggles every 10 ticks
    wb_write(5'd1, 8'h09);
    wb_read("t2_audf_rb", 5'd1, 8'h09);
    wait_vld();
    cur = sample;
    n = 0;
    do begin wait_vld(); n++; end while (sample == cur && n < 40);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(10);
      cur = sample;
      n = 0;
      do begin wait_vld(); n++; end while (sample == cur && n < 40);
      e = exp_q.pop_front();
      chk("t2_half_period", 32'(n), 32'(e));
    end

    // Address decode, unused bits, handshake under held strobe
    wb_write(5'd8, 8'hAB);
    wb_read("t5_adr8", 5'd8, 8'h00);
    wb_read("t5_adr31", 5'd31, 8'h00);
    wb_read("t5_ch0_unaliased", 5'd0, 8'h04);
    wb_write(5'd3, 8'hFF);
    wb_read("t5_reserved", 5'd3, 8'h00);
    wb_write(5'd5, 8'hFF);
    wb_read("t5_audf1_mask", 5'd5, 8'h1F);
    wb_write(5'd4, 8'hF7);
    wb_read("t5_audc1_mask", 5'd4, 8'h07);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 5'd1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1) cnt++;
    end
    stb = 1'b0;
    chk("t5_held_stb_acks", 32'(cnt), 32'd4);

    // Both channels constant high at full volume
    wb_write(5'd0, 8'h00);
    wb_write(5'd1, 8'h00);
    wb_write(5'd4, 8'h00);
    wb_write(5'd5, 8'h00);
    wb_write(5'd6, 8'h0F);
    for (int i = 0; i < 40; i++) wait_vld();
    for (int i = 0; i < 3; i++) exp_q.push_back(30);
    for (int i = 0; i < 3; i++) begin
      wait_vld();
      e = exp_q.pop_front();
      chk("t4_mix30", 32'(sample), 32'(e));
    end
    cnt = 0;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      if (audio === 1'b1) cnt++;
    end
    chk("t4_duty_30_of_64", 32'((cnt >= 299) && (cnt <= 301)), 32'd1);
    wb_write(5'd2, 8'h00);
    wb_write(5'd6, 8'h00);
    for (int i = 0; i < 3; i++) wait_vld();
    exp_q.push_back(0);
    wait_vld();
    e = exp_q.pop_front();
    chk("t4_mix0", 32'(sample), 32'(e));
    cnt = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (audio !== 1'b0) cnt++;
    end
    chk("t4_silent_pdm", 32'(cnt), 32'd0);

    // Asynchronous reset mid-tone and mid-transfer
    wb_write(5'd0, 8'h04);
    wb_write(5'd2, 8'h0F);
    n = 0;
    do begin wait_vld(); n++; end while (sample != 15 && n < 4);
    chk("t6_tone_before_rst", 32'(sample), 32'd15);
    stb = 1'b1; we = 1'b0; adr = 5'd2;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ack", 32'(ack), 32'd0);
    chk("t6_rst_dat", 32'(rdat), 32'd0);
    chk("t6_rst_sample", 32'(sample), 32'd0);
    chk("t6_rst_audio", 32'(audio), 32'd0);
    chk("t6_rst_vld", 32'(vld), 32'd0);
    stb = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Poly9 waveform from the reset seed, covering more than one 511-step period
    wb_write(5'd0, 8'h08);
    wb_write(5'd2, 8'h0F);
    for (int k = 2; k <= 541; k++) exp_q.push_back(p9_seq[k-1] ? 15 : 0);
    for (int i = 0; i < 541; i++) begin
      wait_vld();
      idx = vld_cnt + 1;
      if (idx >= 2 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("t3_poly9", 32'(sample), 32'(e));
      end
    end
    chk("t3_all_consumed", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
